// File: rtl/prt_lb_mst.sv
// Local bus master: turns single-cycle host read/write pulses into level strobes,
// holds address/data through the access, and returns a one-cycle ack with status.
module prt_lb_mst #(
    parameter int P_STB_LEN = 4,
    parameter int P_GAP_LEN = 2,
    parameter int P_TIMEOUT = 255
) (
    input  logic        CLK_IN,
    input  logic        RST_IN,
    input  logic [21:0] HOST_ADR_IN,
    input  logic [31:0] HOST_DAT_IN,
    input  logic        HOST_WR_IN,
    input  logic        HOST_RD_IN,
    output logic [31:0] HOST_DAT_OUT,
    output logic        HOST_ACK_OUT,
    output logic        HOST_ERR_OUT,
    output logic        HOST_BUSY_OUT,
    output logic [21:0] LB_ADR_OUT,
    output logic [31:0] LB_DAT_OUT,
    output logic        LB_WR_OUT,
    output logic        LB_RD_OUT,
    input  logic [31:0] LB_DAT_IN,
    input  logic        LB_VLD_IN
);

    localparam int CNT_MAX = (P_TIMEOUT > P_STB_LEN)
                           ? ((P_TIMEOUT > P_GAP_LEN) ? P_TIMEOUT : P_GAP_LEN)
                           : ((P_STB_LEN > P_GAP_LEN) ? P_STB_LEN : P_GAP_LEN);
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] STB_LAST  = CW'(P_STB_LEN);
    localparam logic [CW-1:0] GAP_LAST  = CW'(P_GAP_LEN);
    localparam logic [CW-1:0] TO_LAST   = CW'(P_TIMEOUT);
    localparam logic [CW-1:0] VLD_FIRST = CW'(3);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [21:0] adr_q, adr_d;
    logic [31:0] lb_dat_q, lb_dat_d;
    logic [31:0] host_dat_q, host_dat_d;
    logic        wr_q, wr_d, rd_q, rd_d;
    logic        ack_q, ack_d, err_q, err_d, busy_q, busy_d;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values of its peers; blocking here would create order races.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            adr_q      <= '0;
            lb_dat_q   <= '0;
            host_dat_q <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            lb_dat_q   <= lb_dat_d;
            host_dat_q <= host_dat_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default before the case so no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        lb_dat_d   = lb_dat_q;
        host_dat_d = host_dat_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (HOST_WR_IN && !HOST_RD_IN) begin
                    adr_d    = HOST_ADR_IN;
                    lb_dat_d = HOST_DAT_IN;
                    wr_d     = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = CNT_ONE;
                    state_d  = S_WR;
                end else if (HOST_RD_IN && !HOST_WR_IN) begin
                    adr_d   = HOST_ADR_IN;
                    rd_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = S_RD;
                end else if (HOST_RD_IN && HOST_WR_IN) begin
                    ack_d = 1'b1;
                    err_d = 1'b1;
                end
            end
            S_WR: begin
                if (cnt_q == STB_LAST) begin
                    wr_d    = 1'b0;
                    ack_d   = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RD: begin
                // Valid in the first two strobe cycles is stale mux pipeline data.
                if (LB_VLD_IN && cnt_q >= VLD_FIRST) begin
                    host_dat_d = LB_DAT_IN;
                    rd_d       = 1'b0;
                    ack_d      = 1'b1;
                    cnt_d      = CNT_ONE;
                    state_d    = S_GAP;
                end else if (cnt_q == TO_LAST) begin
                    host_dat_d = '0;
                    rd_d       = 1'b0;
                    ack_d      = 1'b1;
                    err_d      = 1'b1;
                    cnt_d      = CNT_ONE;
                    state_d    = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign HOST_DAT_OUT  = host_dat_q;
    assign HOST_ACK_OUT  = ack_q;
    assign HOST_ERR_OUT  = err_q;
    assign HOST_BUSY_OUT = busy_q;
    assign LB_ADR_OUT    = adr_q;
    assign LB_DAT_OUT    = lb_dat_q;
    assign LB_WR_OUT     = wr_q;
    assign LB_RD_OUT     = rd_q;

endmodule

// File: tb/tb_prt_lb_mst.sv
// Self-checking bench for prt_lb_mst: directed cases plus randomized transactions
// compared against a transaction-level model of latency, data and status.
module tb_prt_lb_mst;

    localparam int STB    = 4;
    localparam int GAP    = 2;
    localparam int TO     = 255;
    localparam int BUDGET = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [21:0] host_adr = '0;
    logic [31:0] host_dat = '0;
    logic        host_wr = 1'b0;
    logic        host_rd = 1'b0;
    logic [31:0] host_dat_o;
    logic        ack, err, busy;
    logic [21:0] lb_adr;
    logic [31:0] lb_dat_o;
    logic        lb_wr, lb_rd;
    logic [31:0] lb_dat_i = '0;
    logic        lb_vld = 1'b0;

    prt_lb_mst #(.P_STB_LEN(STB), .P_GAP_LEN(GAP), .P_TIMEOUT(TO)) dut (
        .CLK_IN(clk), .RST_IN(rst_n),
        .HOST_ADR_IN(host_adr), .HOST_DAT_IN(host_dat),
        .HOST_WR_IN(host_wr), .HOST_RD_IN(host_rd),
        .HOST_DAT_OUT(host_dat_o), .HOST_ACK_OUT(ack),
        .HOST_ERR_OUT(err), .HOST_BUSY_OUT(busy),
        .LB_ADR_OUT(lb_adr), .LB_DAT_OUT(lb_dat_o),
        .LB_WR_OUT(lb_wr), .LB_RD_OUT(lb_rd),
        .LB_DAT_IN(lb_dat_i), .LB_VLD_IN(lb_vld)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rd = '0;     // model: host read data register
    logic [31:0] lb_dat_exp = '0;  // model: bus write data register

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap_phase(input logic [21:0] adr);
        int g = 0;
        while (busy && g < BUDGET) begin
            check("gap_strobe", {30'b0, lb_wr, lb_rd}, 32'd0);
            check("gap_adr", lb_adr, adr);
            check("gap_dat", lb_dat_o, lb_dat_exp);
            if (g > 0) check("gap_ack", ack, 0);
            step();
            g++;
        end
        check("gap_len", g, GAP);
        check("idle_ack", ack, 0);
    endtask

    task automatic do_write(input logic [21:0] adr, input logic [31:0] dat, input bit inject);
        int lat = 1;
        host_adr = adr; host_dat = dat; host_wr = 1'b1;
        step();
        host_wr = 1'b0;
        lb_dat_exp = dat;
        while (!ack && lat < BUDGET) begin
            check("wr_strobe", {30'b0, lb_wr, lb_rd}, 32'd2);
            check("wr_adr", lb_adr, adr);
            check("wr_dat", lb_dat_o, dat);
            check("wr_busy", busy, 1);
            host_rd  = inject && (lat == 2);
            host_adr = 22'($urandom);
            host_dat = $urandom;
            step();
            lat++;
        end
        host_rd = 1'b0;
        check("wr_lat", lat, 1 + STB);
        check("wr_err", err, 0);
        check("wr_dat_out_hold", host_dat_o, last_rd);
        gap_phase(adr);
    endtask

    // mode 0: single valid pulse at strobe cycle k; 1: valid held from before; 2: never
    task automatic do_read(input logic [21:0] adr, input int mode, input int k,
                           input logic [31:0] rdat);
        int lat = 1;
        int s_exp;
        bit hit;
        case (mode)
            0:       begin hit = (k >= 3 && k <= TO); s_exp = hit ? k : TO; end
            1:       begin hit = 1'b1; s_exp = 3; end
            default: begin hit = 1'b0; s_exp = TO; end
        endcase
        lb_vld   = (mode == 1);
        lb_dat_i = rdat;
        host_adr = adr; host_rd = 1'b1;
        step();
        host_rd = 1'b0;
        while (!ack && lat < BUDGET) begin
            check("rd_strobe", {30'b0, lb_wr, lb_rd}, 32'd1);
            check("rd_adr", lb_adr, adr);
            lb_vld   = (mode == 1) || (mode == 0 && lat == k);
            lb_dat_i = lb_vld ? rdat : $urandom;
            host_adr = 22'($urandom);
            step();
            lat++;
        end
        lb_vld = 1'b0;
        last_rd = hit ? rdat : 32'h0;
        check("rd_lat", lat, s_exp + 1);
        check("rd_err", err, {31'b0, !hit});
        check("rd_data", host_dat_o, last_rd);
        check("rd_strobe_fall", lb_rd, 0);
        gap_phase(adr);
    endtask

    task automatic do_double();
        host_wr = 1'b1; host_rd = 1'b1; host_adr = 22'($urandom);
        step();
        host_wr = 1'b0; host_rd = 1'b0;
        check("dbl_ack", ack, 1);
        check("dbl_err", err, 1);
        check("dbl_busy", busy, 0);
        check("dbl_strobe", {30'b0, lb_wr, lb_rd}, 32'd0);
        check("dbl_dat_hold", host_dat_o, last_rd);
        step();
        check("dbl_ack_once", ack, 0);
        check("dbl_no_strobe", {30'b0, lb_wr, lb_rd}, 32'd0);
    endtask

    task automatic reset_mid_read();
        host_adr = 22'h02_0100; host_rd = 1'b1;
        step();
        host_rd = 1'b0;
        step();
        check("rst_pre_strobe", lb_rd, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_strobe_drop", lb_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_dat_out", host_dat_o, 0);
        last_rd = '0;
        lb_dat_exp = '0;
        step();
        check("rst_no_ack", ack, 0);
        rst_n = 1'b1;
        step();
        do_write(22'h03_0020, 32'h1357_9BDF, 1'b0);
    endtask

    initial begin
        int r, mode, k, idle;
        step();
        step();
        check("reset_ack", ack, 0);
        check("reset_err", err, 0);
        check("reset_busy", busy, 0);
        check("reset_strobes", {30'b0, lb_wr, lb_rd}, 32'd0);
        check("reset_adr", lb_adr, 0);
        check("reset_lb_dat", lb_dat_o, 0);
        check("reset_host_dat", host_dat_o, 0);
        rst_n = 1'b1;
        step();

        do_write(22'h03_0010, 32'hA5A5_1234, 1'b0);
        do_read(22'h01_0004, 0, 4, 32'hCAFE_0001);
        do_read(22'h01_0008, 1, 0, 32'hBEEF_0002);
        do_read(22'h01_000C, 2, 0, 32'hDEAD_0003);
        do_double();
        do_write(22'h04_0000, 32'h0F0F_F0F0, 1'b1);
        do_read(22'h05_0000, 0, TO, 32'h1111_2222);
        do_read(22'h05_0004, 0, 2, 32'h3333_4444);
        reset_mid_read();

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                do_write(22'($urandom), $urandom, bit'($urandom_range(0, 1)));
            end else if (r < 9) begin
                mode = $urandom_range(0, 9);
                mode = (mode < 7) ? 0 : (mode < 9) ? 1 : 2;
                k = ($urandom_range(0, 9) == 0) ? 252 + $urandom_range(0, 4)
                                                 : $urandom_range(1, 10);
                do_read(22'($urandom), mode, k, $urandom);
            end else begin
                do_double();
            end
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prt_lb_mst.md
Name: prt_lb_mst

Overview:
- Local bus master that converts single-cycle host (CPU/bridge) read/write requests into the level-strobe local bus protocol consumed by the local bus mux.
- Sits directly upstream of the mux and drives its upstream port.
- Holds address, data and strobe stable for the whole access, waits for read-valid and enforces a read timeout.
- Returns a single-cycle acknowledge with data and error status to the host.

Parameters:
- P_STB_LEN, 4, write strobe high time in cycles (min 2).
- P_GAP_LEN, 2, strobe low time in cycles between accesses (min 2).
- P_TIMEOUT, 255, max cycles to wait for read valid (min 4).

Ports:
- CLK_IN  in  1  clock.
- RST_IN  in  1  reset, asynchronous, active-low.
- HOST_ADR_IN  in  22  access address; bits 21:16 select the port, bits 15:0 the register.
- HOST_DAT_IN  in  32  write data.
- HOST_WR_IN  in  1  write request pulse.
- HOST_RD_IN  in  1  read request pulse.
- HOST_DAT_OUT  out  32  read data; valid with HOST_ACK_OUT.
- HOST_ACK_OUT  out  1  completion pulse, 1 cycle.
- HOST_ERR_OUT  out  1  error flag; valid with HOST_ACK_OUT.
- HOST_BUSY_OUT  out  1  high while not idle.
- LB_ADR_OUT  out  22  local bus address.
- LB_DAT_OUT  out  32  local bus write data.
- LB_WR_OUT  out  1  write strobe, level.
- LB_RD_OUT  out  1  read strobe, level.
- LB_DAT_IN  in  32  local bus read data.
- LB_VLD_IN  in  1  local bus read data valid.

Behaviour:
- Reset (RST_IN low, async): state IDLE; all outputs 0; counters 0.
- All outputs are registered.
- States: IDLE, WR, RD, GAP.
- IDLE: BUSY=0.
  - HOST_WR_IN=1 and HOST_RD_IN=0: latch ADR and DAT into LB_ADR_OUT and LB_DAT_OUT; LB_WR_OUT=1 from the next cycle; BUSY=1; go to WR.
  - HOST_RD_IN=1 and HOST_WR_IN=0: latch ADR; LB_RD_OUT=1 from the next cycle; BUSY=1; go to RD.
  - Both requests high: no bus access; next cycle ACK=1, ERR=1, DAT_OUT unchanged; stay IDLE.
- Requests arriving while BUSY=1 are ignored (not queued).
- WR: LB_WR_OUT held high exactly P_STB_LEN cycles, then LB_WR_OUT=0; ACK=1, ERR=0 in the same cycle; go to GAP. LB_VLD_IN is ignored.
- RD: LB_RD_OUT held high. Cycle counter starts at 1 on the first strobe-high cycle. LB_VLD_IN is sampled only when counter >= 3, which masks stale valid from the mux pipeline.
  - Valid sampled high: DAT_OUT<=LB_DAT_IN; ACK=1, ERR=0; LB_RD_OUT=0 the same cycle; go to GAP.
  - Counter reaches P_TIMEOUT without valid: DAT_OUT<=32'h0; ACK=1, ERR=1; LB_RD_OUT=0; go to GAP.
  - Valid and timeout in the same cycle: valid wins.
- GAP: both strobes 0 for P_GAP_LEN cycles, guaranteeing a falling edge for the downstream edge detector. LB_ADR_OUT and LB_DAT_OUT hold their values. Then go to IDLE; BUSY=0 in the IDLE cycle.
- Latency:
  - Write: host pulse to ACK = 1+P_STB_LEN cycles.
  - Read: host pulse to ACK = 1+N, where N is the strobe-cycle count at first accepted valid.
  - Back-to-back: the next request may be accepted on the first IDLE cycle.
- HOST_DAT_OUT holds its last value between reads. ACK is never high in two consecutive cycles except for back-to-back double-request errors.
- Counter width: $clog2(P_TIMEOUT+1); no wrap is possible because of the terminal compare.
- Reset mid-access: strobes drop immediately; no ACK is issued.

Test Plan:
- Write ADR=22'h03_0010, DAT=32'hA5A5_1234 -> LB_ADR_OUT and LB_DAT_OUT stable; LB_WR_OUT high exactly 4 cycles; ACK at cycle 5 with ERR=0; strobe low 2 cycles; BUSY drops at cycle 7.
- Read ADR=22'h01_0004, LB_VLD_IN high with LB_DAT_IN=32'hCAFE_0001 at strobe cycle 4 -> DAT_OUT=32'hCAFE_0001, ACK cycle 5, ERR=0, LB_RD_OUT falls the same cycle.
- Read with LB_VLD_IN held high from before the request -> valid ignored at strobe cycles 1-2; completes at strobe cycle 3 with ERR=0.
- Read with LB_VLD_IN never high -> ACK after 255 strobe cycles, ERR=1, DAT_OUT=0; then 2 gap cycles; BUSY=0.
- HOST_WR_IN and HOST_RD_IN both high in IDLE -> no strobe; ACK=1, ERR=1 next cycle. Second request pulse during WR -> ignored; exactly one ACK issued.
- RST_IN low at strobe cycle 2 of a read -> LB_RD_OUT=0 asynchronously, no ACK; after release, a write completes normally.
